write_back_arbiter: RTL and testbench
=====================================

Name: write_back_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline write-back result (the output of the WB select mux) and a long-latency unit (e.g. mul/div).
- Results from the long-latency unit are buffered in a small FIFO.
- The pipeline has priority.
- A starvation counter forces a pipeline stall so that buffered results drain.
- Register-file write outputs are registered.

Parameters:
- DATA_WIDTH, 32, register data width
- REG_ADDR_WIDTH, 5, destination register index width
- FIFO_DEPTH, 2, long-latency result buffer entries; power of 2, at least 2
- STARVE_LIMIT, 4, consecutive lost arbitrations before the FIFO is forced; at least 1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipeValid  in  1  pipeline WB stage holds a result
- pipeRd  in  REG_ADDR_WIDTH  pipeline destination register
- pipeData  in  DATA_WIDTH  pipeline result (WB mux output)
- pipeStall  out  1  combinational; pipeline must hold its WB stage this cycle
- lcValid  in  1  long-latency unit offers a result
- lcRd  in  REG_ADDR_WIDTH  long-latency destination register
- lcData  in  DATA_WIDTH  long-latency result
- lcReady  out  1  FIFO can accept; equals (count < FIFO_DEPTH), derived from registered count
- regWrite  out  1  registered register-file write enable
- regWriteAddr  out  REG_ADDR_WIDTH  registered write address
- regWriteData  out  DATA_WIDTH  registered write data
- fifoCount  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, any time, including mid-drain):
  - FIFO pointers, count and starvation counter cleared.
  - regWrite=0, regWriteAddr=0, regWriteData=0, fifoCount=0.
  - lcReady=1 once reset is released; pipeStall=0.
- Push: on a clock edge where lcValid && lcReady, {lcRd, lcData} is written at the tail.
  - lcReady uses the pre-edge count. When full, no push occurs even if a pop happens in the same cycle.
- Arbitration, evaluated each cycle (head = oldest FIFO entry, visible the cycle after its push):
  - FIFO empty: grant pipeline if pipeValid.
  - FIFO non-empty, pipeValid=0: grant FIFO head (pop).
  - FIFO non-empty, pipeValid=1, starveCnt < STARVE_LIMIT: grant pipeline; starveCnt increments.
  - FIFO non-empty, pipeValid=1, starveCnt == STARVE_LIMIT: grant FIFO head (pop); pipeStall=1; starveCnt cleared. The pipeline presents the same result next cycle.
  - starveCnt is cleared whenever the FIFO is granted or is empty.
- Output register: at the edge ending a granted cycle, regWriteAddr and regWriteData take the granted rd and data, and regWrite=1. Otherwise regWrite=0 and the address/data hold their previous values.
- Latency:
  - Pipeline: 1 cycle.
  - Long-latency unit, uncontended: 2 cycles (push edge, then pop edge).
- rd==0: the granted entry is consumed (popped, or the pipeline is accepted) but regWrite stays 0.
- Push and pop on the same edge: count unchanged; pointers both advance, wrapping modulo FIFO_DEPTH.
- pipeStall is asserted only in the forced-FIFO case, never when pipeValid=0.
- FIFO entries drain in strict push order.

Optional Feature:
- Macro: WB_HAZARD_QUERY_EN.
- Defined:
  - Adds ports queryRd (in, REG_ADDR_WIDTH) and queryHit (out, 1).
  - queryHit is combinational: 1 when queryRd != 0 and it matches the rd of any valid FIFO entry, or of an lcValid&&lcReady push in the current cycle.
  - Decode uses queryHit to stall on pending long-latency destinations.
- Not defined: the ports are absent and no comparators are built.

Test Plan:
- Reset then idle; pipeValid=1, pipeRd=5, pipeData=0xDEADBEEF for one cycle -> next cycle regWrite=1, regWriteAddr=5, regWriteData=0xDEADBEEF; fifoCount=0.
- Pipeline idle; lcValid=1, lcRd=7, lcData=0x12 for one cycle -> fifoCount=1 after the edge; regWrite=1, addr 7, data 0x12 one cycle later; fifoCount back to 0.
- Push 2 entries (rd 3, rd 4) while pipeValid=1 continuously -> lcReady=0 with count 2; pipeline granted 4 cycles; 5th cycle pipeStall=1 and rd 3 written; after 4 more pipeline grants, rd 4 written.
- Full FIFO, lcValid=1, pipeValid=0 -> pop occurs but no push that edge; push is accepted the following edge; entries written in order.
- Pipeline rd=0 with data 0xFF -> regWrite stays 0; FIFO pop of an rd=0 entry also yields no write but decrements fifoCount.
- Assert rst_n=0 mid-cycle with 2 entries queued -> immediately fifoCount=0, regWrite=0; after release no stale entries are written. With WB_HAZARD_QUERY_EN defined: queryRd=9 while an entry with rd 9 is queued -> queryHit=1; after the pop -> 0.

Source files
------------

// File: rtl/write_back_arbiter.sv
// -----------------------------------------------------------------------------
// write_back_arbiter
//
// Purpose:
//   Shares the single register-file write port between the in-order pipeline
//   write-back result and a long-latency unit (mul/div).  Long-latency results
//   are buffered in a small FIFO.  The pipeline normally wins arbitration; a
//   starvation counter forces one FIFO drain (stalling the pipeline) after
//   STARVE_LIMIT consecutive lost arbitrations.  The register-file write
//   outputs are registered.
//
// Optional feature macro: WB_HAZARD_QUERY_EN
//   When defined, adds queryRd/queryHit so decode can detect a pending
//   long-latency destination (queued in the FIFO or being pushed this cycle).
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   pipeValid/pipeRd/pipeData  pipeline WB-stage result
//   pipeStall               combinational; pipeline must hold its WB stage
//   lcValid/lcRd/lcData     long-latency unit result offer
//   lcReady                 FIFO can accept (count < FIFO_DEPTH)
//   regWrite/regWriteAddr/regWriteData  registered register-file write port
//   fifoCount               current FIFO occupancy
//   queryRd/queryHit        (WB_HAZARD_QUERY_EN only) pending-destination query
// -----------------------------------------------------------------------------
module write_back_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipeValid,
  input  logic [REG_ADDR_WIDTH-1:0]     pipeRd,
  input  logic [DATA_WIDTH-1:0]         pipeData,
  output logic                          pipeStall,
  input  logic                          lcValid,
  input  logic [REG_ADDR_WIDTH-1:0]     lcRd,
  input  logic [DATA_WIDTH-1:0]         lcData,
  output logic                          lcReady,
  output logic                          regWrite,
  output logic [REG_ADDR_WIDTH-1:0]     regWriteAddr,
  output logic [DATA_WIDTH-1:0]         regWriteData,
`ifdef WB_HAZARD_QUERY_EN
  input  logic [REG_ADDR_WIDTH-1:0]     queryRd,
  output logic                          queryHit,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [REG_ADDR_WIDTH-1:0] RD_ZERO = {REG_ADDR_WIDTH{1'b0}};

  // FIFO storage and bookkeeping
  logic [REG_ADDR_WIDTH-1:0] rd_mem_r   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem_r [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_r;
  logic [PW-1:0]             rd_ptr_r;
  logic [CW-1:0]             count_r;
  logic [SW-1:0]             starve_cnt_r;

  // Registered write port
  logic                      reg_write_r;
  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_r;
  logic [DATA_WIDTH-1:0]     reg_write_data_r;

  // Combinational arbitration results
  logic                      fifo_empty_s;
  logic                      lc_ready_s;
  logic                      push_s;
  logic                      grant_pipe_s;
  logic                      grant_fifo_s;
  logic                      stall_s;
  logic                      grant_s;
  logic [REG_ADDR_WIDTH-1:0] grant_rd_s;
  logic [DATA_WIDTH-1:0]     grant_data_s;
  logic [SW-1:0]             starve_next_s;
  logic [CW-1:0]             count_next_s;

  // The push decision uses the pre-edge count, so a full FIFO never accepts
  // a push even when it pops on the same edge.
  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign lc_ready_s   = (count_r < CW'(FIFO_DEPTH));
  assign push_s       = lcValid && lc_ready_s;

  // Arbitration: pipeline first, FIFO when pipeline idle or starved too long.
  always_comb begin
    grant_pipe_s  = 1'b0;
    grant_fifo_s  = 1'b0;
    stall_s       = 1'b0;
    starve_next_s = starve_cnt_r;
    if (fifo_empty_s) begin
      grant_pipe_s  = pipeValid;
      starve_next_s = {SW{1'b0}};
    end else if (!pipeValid) begin
      grant_fifo_s  = 1'b1;
      starve_next_s = {SW{1'b0}};
    end else if (starve_cnt_r < SW'(STARVE_LIMIT)) begin
      grant_pipe_s  = 1'b1;
      starve_next_s = starve_cnt_r + SW'(1);
    end else begin
      // Forced drain: pipeline holds its result and re-presents it next cycle.
      grant_fifo_s  = 1'b1;
      stall_s       = 1'b1;
      starve_next_s = {SW{1'b0}};
    end
  end

  // Select the winning destination/data for the output register.
  always_comb begin
    grant_s = grant_pipe_s || grant_fifo_s;
    if (grant_fifo_s) begin
      grant_rd_s   = rd_mem_r[rd_ptr_r];
      grant_data_s = data_mem_r[rd_ptr_r];
    end else begin
      grant_rd_s   = pipeRd;
      grant_data_s = pipeData;
    end
  end

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    case ({push_s, grant_fifo_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers, storage, occupancy and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      starve_cnt_r <= {SW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        rd_mem_r[i]   <= RD_ZERO;
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        rd_mem_r[wr_ptr_r]   <= lcRd;
        data_mem_r[wr_ptr_r] <= lcData;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      if (grant_fifo_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r      <= count_next_s;
      starve_cnt_r <= starve_next_s;
    end
  end

  // Register-file write port. A granted rd==0 is consumed without a write,
  // and address/data hold so the port only moves on real writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_r      <= 1'b0;
      reg_write_addr_r <= RD_ZERO;
      reg_write_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      if (grant_s && (grant_rd_s != RD_ZERO)) begin
        reg_write_r      <= 1'b1;
        reg_write_addr_r <= grant_rd_s;
        reg_write_data_r <= grant_data_s;
      end else begin
        reg_write_r <= 1'b0;
      end
    end
  end

`ifdef WB_HAZARD_QUERY_EN
  logic query_hit_s;

  // Match queryRd against every occupied FIFO slot plus the current push.
  always_comb begin
    query_hit_s = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CW'(i) < count_r) && (rd_mem_r[rd_ptr_r + PW'(i)] == queryRd)) begin
        query_hit_s = 1'b1;
      end else begin
        query_hit_s = query_hit_s;
      end
    end
    if (push_s && (lcRd == queryRd)) begin
      query_hit_s = 1'b1;
    end else begin
      query_hit_s = query_hit_s;
    end
    // x0 is never a real hazard.
    if (queryRd == RD_ZERO) begin
      query_hit_s = 1'b0;
    end else begin
      query_hit_s = query_hit_s;
    end
  end

  assign queryHit = query_hit_s;
`endif

  assign pipeStall    = stall_s;
  assign lcReady      = lc_ready_s;
  assign regWrite     = reg_write_r;
  assign regWriteAddr = reg_write_addr_r;
  assign regWriteData = reg_write_data_r;
  assign fifoCount    = count_r;

endmodule

// File: tb/tb_write_back_arbiter.sv
// -----------------------------------------------------------------------------
// tb_write_back_arbiter
//
// Self-checking bench for write_back_arbiter: table of directed vectors with
// hand-computed expectations, plus hand-written reset and hazard-query
// sequences. Inputs are driven on the falling edge; combinational outputs are
// checked 1ns later, registered outputs 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_write_back_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipeValid;
  logic [4:0]  pipeRd;
  logic [31:0] pipeData;
  logic        pipeStall;
  logic        lcValid;
  logic [4:0]  lcRd;
  logic [31:0] lcData;
  logic        lcReady;
  logic        regWrite;
  logic [4:0]  regWriteAddr;
  logic [31:0] regWriteData;
  logic [1:0]  fifoCount;
  logic [4:0]  queryRd;
  logic        queryHit;

  int checks = 0;
  int errors = 0;

  write_back_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipeValid    (pipeValid),
    .pipeRd       (pipeRd),
    .pipeData     (pipeData),
    .pipeStall    (pipeStall),
    .lcValid      (lcValid),
    .lcRd         (lcRd),
    .lcData       (lcData),
    .lcReady      (lcReady),
    .regWrite     (regWrite),
    .regWriteAddr (regWriteAddr),
    .regWriteData (regWriteData),
`ifdef WB_HAZARD_QUERY_EN
    .queryRd      (queryRd),
    .queryHit     (queryHit),
`endif
    .fifoCount    (fifoCount)
  );

`ifndef WB_HAZARD_QUERY_EN
  assign queryHit = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        e_stall;
    logic        e_ready;
    logic        e_we;
    logic        c_addr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                              input logic e_stall, input logic e_ready, input logic e_we,
                              input logic c_addr, input logic [4:0] e_addr,
                              input logic [31:0] e_data, input logic [1:0] e_cnt);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pdata = pdata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_we = e_we;
    v.c_addr = c_addr; v.e_addr = e_addr; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %0h required %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    pipeValid = 1'b0; pipeRd = 5'd0; pipeData = 32'h0;
    lcValid = 1'b0; lcRd = 5'd0; lcData = 32'h0;
    queryRd = 5'd0;
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    pipeValid = v.pv; pipeRd = v.prd; pipeData = v.pdata;
    lcValid = v.lv; lcRd = v.lrd; lcData = v.ldata;
    #1;
    chk("pipeStall", idx, {31'd0, pipeStall}, {31'd0, v.e_stall});
    chk("lcReady", idx, {31'd0, lcReady}, {31'd0, v.e_ready});
    @(posedge clk);
    #1;
    chk("regWrite", idx, {31'd0, regWrite}, {31'd0, v.e_we});
    chk("fifoCount", idx, {30'd0, fifoCount}, {30'd0, v.e_cnt});
    if (v.c_addr) begin
      chk("regWriteAddr", idx, {27'd0, regWriteAddr}, {27'd0, v.e_addr});
      chk("regWriteData", idx, regWriteData, v.e_data);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_regWrite", 0, {31'd0, regWrite}, 32'd0);
    chk("rst_addr", 0, {27'd0, regWriteAddr}, 32'd0);
    chk("rst_data", 0, regWriteData, 32'd0);
    chk("rst_count", 0, {30'd0, fifoCount}, 32'd0);
    chk("rst_stall", 0, {31'd0, pipeStall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 0, {31'd0, lcReady}, 32'd1);

    //               pv   prd    pdata          lv   lrd    ldata        stl  rdy  we   ca   addr   data           cnt
    // pipeline single write, 1-cycle latency
    tbl.push_back(mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd5, 32'hDEADBEEF, 2'd0));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b0,1'b1,5'd5, 32'hDEADBEEF, 2'd0));
    // uncontended long-latency result: push edge, then pop edge
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h12,     1'b0,1'b1,1'b0,1'b1,5'd5, 32'hDEADBEEF, 2'd1));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd7, 32'h12,       2'd0));
    // pipeline rd==0 consumed without a write
    tbl.push_back(mk(1'b1, 5'd0, 32'hFF,       1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b0,1'b0,5'd0, 32'h0,        2'd0));
    // starvation: push rd3, rd4 under continuous pipeline traffic
    tbl.push_back(mk(1'b1, 5'd10, 32'hA0,      1'b1, 5'd3, 32'h33,     1'b0,1'b1,1'b1,1'b1,5'd10,32'hA0,       2'd1));
    tbl.push_back(mk(1'b1, 5'd11, 32'hA1,      1'b1, 5'd4, 32'h44,     1'b0,1'b1,1'b1,1'b1,5'd11,32'hA1,       2'd2));
    tbl.push_back(mk(1'b1, 5'd12, 32'hA2,      1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b1,5'd12,32'hA2,       2'd2));
    tbl.push_back(mk(1'b1, 5'd13, 32'hA3,      1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b1,5'd13,32'hA3,       2'd2));
    tbl.push_back(mk(1'b1, 5'd14, 32'hA4,      1'b0, 5'd0, 32'h0,      1'b0,1'b0,1'b1,1'b1,5'd14,32'hA4,       2'd2));
    tbl.push_back(mk(1'b1, 5'd15, 32'hA5,      1'b0, 5'd0, 32'h0,      1'b1,1'b0,1'b1,1'b1,5'd3, 32'h33,       2'd1));
    tbl.push_back(mk(1'b1, 5'd15, 32'hA5,      1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd15,32'hA5,       2'd1));
    tbl.push_back(mk(1'b1, 5'd16, 32'hA6,      1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd16,32'hA6,       2'd1));
    tbl.push_back(mk(1'b1, 5'd17, 32'hA7,      1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd17,32'hA7,       2'd1));
    tbl.push_back(mk(1'b1, 5'd18, 32'hA8,      1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd18,32'hA8,       2'd1));
    tbl.push_back(mk(1'b1, 5'd19, 32'hA9,      1'b0, 5'd0, 32'h0,      1'b1,1'b1,1'b1,1'b1,5'd4, 32'h44,       2'd0));
    tbl.push_back(mk(1'b1, 5'd19, 32'hA9,      1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd19,32'hA9,       2'd0));
    // full FIFO: pop without push, push accepted next edge, strict order
    tbl.push_back(mk(1'b1, 5'd22, 32'h300,     1'b1, 5'd20, 32'h200,   1'b0,1'b1,1'b1,1'b1,5'd22,32'h300,      2'd1));
    tbl.push_back(mk(1'b1, 5'd23, 32'h301,     1'b1, 5'd21, 32'h201,   1'b0,1'b1,1'b1,1'b1,5'd23,32'h301,      2'd2));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd24, 32'h202,   1'b0,1'b0,1'b1,1'b1,5'd20,32'h200,      2'd1));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd24, 32'h202,   1'b0,1'b1,1'b1,1'b1,5'd21,32'h201,      2'd1));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b1,1'b1,5'd24,32'h202,      2'd0));
    // FIFO entry with rd==0: popped, no write
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55,     1'b0,1'b1,1'b0,1'b1,5'd24,32'h202,      2'd1));
    tbl.push_back(mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,      1'b0,1'b1,1'b0,1'b0,5'd0, 32'h0,        2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], i + 1);
    end

`ifdef WB_HAZARD_QUERY_EN
    // hazard query: hit on current push, hit while queued, clear after pop
    @(negedge clk);
    pipeValid = 1'b1; pipeRd = 5'd30; pipeData = 32'h1;
    lcValid = 1'b1; lcRd = 5'd9; lcData = 32'h99; queryRd = 5'd9;
    #1;
    chk("qhit_push", 100, {31'd0, queryHit}, 32'd1);
    @(negedge clk);
    pipeRd = 5'd31; lcValid = 1'b0;
    #1;
    chk("qhit_queued", 101, {31'd0, queryHit}, 32'd1);
    queryRd = 5'd8;
    #1;
    chk("qhit_other", 102, {31'd0, queryHit}, 32'd0);
    queryRd = 5'd9;
    @(negedge clk);
    pipeValid = 1'b0;
    #1;
    chk("qhit_prepop", 103, {31'd0, queryHit}, 32'd1);
    @(posedge clk);
    #1;
    chk("qpop_write", 104, {27'd0, regWriteAddr}, 32'd9);
    @(negedge clk);
    #1;
    chk("qhit_after", 105, {31'd0, queryHit}, 32'd0);
    idle_inputs();
`endif

    // mid-cycle reset with two entries queued
    @(negedge clk);
    idle_inputs();
    pipeValid = 1'b1; pipeRd = 5'd26; pipeData = 32'h26;
    lcValid = 1'b1; lcRd = 5'd25; lcData = 32'h25;
    @(negedge clk);
    pipeRd = 5'd28; pipeData = 32'h28;
    lcRd = 5'd27; lcData = 32'h27;
    @(posedge clk);
    #1;
    chk("pre_rst_count", 200, {30'd0, fifoCount}, 32'd2);
    chk("pre_rst_we", 200, {31'd0, regWrite}, 32'd1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("mid_rst_count", 201, {30'd0, fifoCount}, 32'd0);
    chk("mid_rst_we", 201, {31'd0, regWrite}, 32'd0);
    chk("mid_rst_addr", 201, {27'd0, regWriteAddr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_we", 202 + i, {31'd0, regWrite}, 32'd0);
      chk("post_rst_count", 202 + i, {30'd0, fifoCount}, 32'd0);
      chk("post_rst_ready", 202 + i, {31'd0, lcReady}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
